// File: rtl/regfile_mp.sv
// regfile_mp: parametrised multi-port register file with a busy scoreboard.
//
// NREGS registers of WIDTH bits, two combinational read ports, one
// synchronous write port. A per-register busy bit is set by a reserve
// (a producer has been issued) and cleared by the matching writeback, so a
// controller can stall on read-after-write hazards.
//
// Parameters:
//   WIDTH    data width of each register
//   NREGS    number of registers (2..64, any value)
//   BYPASS   1 = same-cycle write is forwarded to the read ports
//   ZERO_REG 1 = register 0 reads 0, ignores writes and is never busy
//   AW       address width, derived from NREGS
//
// Ports:
//   clk                 system clock, rising edge
//   rst_n               synchronous active-low reset
//   wr_en/addr/data     write port, 1-cycle latency
//   rsv_en/addr         reserve port, marks a register busy
//   rd0_addr/data/busy  read port 0 (combinational)
//   rd1_addr/data/busy  read port 1 (combinational)
//   busy_vec            registered scoreboard, bit i = register i busy
module regfile_mp #(
  parameter int WIDTH    = 16,
  parameter int NREGS    = 8,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 0,
  localparam int AW      = (NREGS > 1) ? $clog2(NREGS) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rsv_en,
  input  logic [AW-1:0]    rsv_addr,
  input  logic [AW-1:0]    rd0_addr,
  output logic [WIDTH-1:0] rd0_data,
  output logic             rd0_busy,
  input  logic [AW-1:0]    rd1_addr,
  output logic [WIDTH-1:0] rd1_data,
  output logic             rd1_busy,
  output logic [NREGS-1:0] busy_vec
);

  // One extra bit so that NREGS itself is representable for the compare.
  localparam logic [AW:0] LIMIT = (AW+1)'(NREGS);

  // Non-power-of-2 sizes leave holes at the top of the address space, and
  // register 0 is excluded entirely when it is hardwired to zero.
  function automatic logic addr_valid(input logic [AW-1:0] a);
    logic ok;
    ok = ({1'b0, a} < LIMIT);
    if ((ZERO_REG != 0) && (a == '0)) ok = 1'b0;
    return ok;
  endfunction

  logic [WIDTH-1:0] regs [NREGS];
  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] busy_d;
  logic [NREGS-1:0] wr_sel;
  logic [NREGS-1:0] rsv_sel;
  logic             wr_ok;
  logic             rsv_ok;

  assign wr_ok  = wr_en  && addr_valid(wr_addr);
  assign rsv_ok = rsv_en && addr_valid(rsv_addr);

  // One-hot decode; invalid addresses decode to nothing, so they have no
  // side effects on data or scoreboard.
  always_comb begin
    wr_sel  = '0;
    rsv_sel = '0;
    for (int i = 0; i < NREGS; i++) begin
      wr_sel[i]  = wr_ok  && (wr_addr  == AW'(i));
      rsv_sel[i] = rsv_ok && (rsv_addr == AW'(i));
    end
  end

  // Reserve is applied after the clear: a same-index write and reserve
  // leaves the register busy because a new producer has been issued.
  assign busy_d = (busy_q & ~wr_sel) | rsv_sel;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy_q <= '0;
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else begin
      busy_q <= busy_d;
      for (int i = 0; i < NREGS; i++) begin
        if (wr_sel[i]) regs[i] <= wr_data;
      end
    end
  end

  assign busy_vec = busy_q;

  logic [1:0][AW-1:0] rd_addr;
  assign rd_addr = {rd1_addr, rd0_addr};

  for (genvar p = 0; p < 2; p++) begin : g_rd
    logic             ok;
    logic             hit;
    logic [WIDTH-1:0] data;
    logic             busy;

    assign ok  = addr_valid(rd_addr[p]);
    // wr_ok already implies a valid address, so a hit implies ok. The
    // forward is independent of rst_n.
    assign hit = (BYPASS != 0) && wr_ok && (wr_addr == rd_addr[p]);

    always_comb begin
      data = '0;
      busy = 1'b0;
      for (int i = 0; i < NREGS; i++) begin
        if (ok && (rd_addr[p] == AW'(i))) begin
          data = regs[i];
          busy = busy_q[i];
        end
      end
      if (hit) begin
        data = wr_data;
        busy = 1'b0;
      end
    end

    if (p == 0) begin : g_p0
      assign rd0_data = data;
      assign rd0_busy = busy;
    end else begin : g_p1
      assign rd1_data = data;
      assign rd1_busy = busy;
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Testbench for regfile_mp: a default build (8x16, bypass) and a
// 6x32 build with zero register and no bypass, both against a
// behavioural array model.
module tb_regfile_mp;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // build A: WIDTH=16 NREGS=8 BYPASS=1 ZERO_REG=0
  logic        a_wr_en, a_rsv_en;
  logic [2:0]  a_wr_addr, a_rsv_addr, a_rd0_addr, a_rd1_addr;
  logic [15:0] a_wr_data, a_rd0_data, a_rd1_data;
  logic        a_rd0_busy, a_rd1_busy;
  logic [7:0]  a_busy_vec;

  // build B: WIDTH=32 NREGS=6 BYPASS=0 ZERO_REG=1
  logic        b_wr_en, b_rsv_en;
  logic [2:0]  b_wr_addr, b_rsv_addr, b_rd0_addr, b_rd1_addr;
  logic [31:0] b_wr_data, b_rd0_data, b_rd1_data;
  logic        b_rd0_busy, b_rd1_busy;
  logic [5:0]  b_busy_vec;

  regfile_mp #(.WIDTH(16), .NREGS(8), .BYPASS(1), .ZERO_REG(0)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .wr_en(a_wr_en), .wr_addr(a_wr_addr), .wr_data(a_wr_data),
    .rsv_en(a_rsv_en), .rsv_addr(a_rsv_addr),
    .rd0_addr(a_rd0_addr), .rd0_data(a_rd0_data), .rd0_busy(a_rd0_busy),
    .rd1_addr(a_rd1_addr), .rd1_data(a_rd1_data), .rd1_busy(a_rd1_busy),
    .busy_vec(a_busy_vec)
  );

  regfile_mp #(.WIDTH(32), .NREGS(6), .BYPASS(0), .ZERO_REG(1)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data),
    .rsv_en(b_rsv_en), .rsv_addr(b_rsv_addr),
    .rd0_addr(b_rd0_addr), .rd0_data(b_rd0_data), .rd0_busy(b_rd0_busy),
    .rd1_addr(b_rd1_addr), .rd1_data(b_rd1_data), .rd1_busy(b_rd1_busy),
    .busy_vec(b_busy_vec)
  );

  // ---------------- reference model ----------------
  logic [15:0] ma [8];
  bit          ba [8];
  logic [31:0] mb [6];
  bit          bb [6];

  function automatic bit valid_b(input logic [2:0] ad);
    return (int'(ad) < 6) && (ad != 3'd0);
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) begin ma[i] = '0; ba[i] = 0; end
      for (int i = 0; i < 6; i++) begin mb[i] = '0; bb[i] = 0; end
    end else begin
      if (a_wr_en) begin ma[a_wr_addr] = a_wr_data; ba[a_wr_addr] = 0; end
      if (a_rsv_en) ba[a_rsv_addr] = 1;
      if (b_wr_en && valid_b(b_wr_addr)) begin mb[b_wr_addr] = b_wr_data; bb[b_wr_addr] = 0; end
      if (b_rsv_en && valid_b(b_rsv_addr)) bb[b_rsv_addr] = 1;
    end
  end

  function automatic logic [15:0] exp_a_data(input logic [2:0] ad);
    if (a_wr_en && a_wr_addr == ad) return a_wr_data;
    return ma[ad];
  endfunction

  function automatic logic exp_a_busy(input logic [2:0] ad);
    if (a_wr_en && a_wr_addr == ad) return 1'b0;
    return ba[ad];
  endfunction

  function automatic logic [7:0] exp_a_vec();
    logic [7:0] v;
    for (int i = 0; i < 8; i++) v[i] = ba[i];
    return v;
  endfunction

  function automatic logic [31:0] exp_b_data(input logic [2:0] ad);
    if (!valid_b(ad)) return '0;
    return mb[ad];
  endfunction

  function automatic logic exp_b_busy(input logic [2:0] ad);
    if (!valid_b(ad)) return 1'b0;
    return bb[ad];
  endfunction

  function automatic logic [5:0] exp_b_vec();
    logic [5:0] v;
    for (int i = 0; i < 6; i++) v[i] = bb[i];
    return v;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic drive_idle();
    a_wr_en = 0; a_wr_addr = 0; a_wr_data = 0; a_rsv_en = 0; a_rsv_addr = 0;
    b_wr_en = 0; b_wr_addr = 0; b_wr_data = 0; b_rsv_en = 0; b_rsv_addr = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 0;
    for (int c = 0; c < 3; c++) begin
      tick();
      a_wr_en = 1; a_wr_addr = 3'($urandom_range(0, 7)); a_wr_data = 16'($urandom);
      a_rsv_en = 1; a_rsv_addr = 3'($urandom_range(0, 7));
      b_wr_en = 1; b_wr_addr = 3'($urandom_range(1, 5)); b_wr_data = $urandom;
      b_rsv_en = 1; b_rsv_addr = 3'($urandom_range(1, 5));
    end
    tick();
    rst_n = 1;
    drive_idle();
    for (int ad = 0; ad < 8; ad++) begin
      if (ad > 0) tick();
      a_rd0_addr = 3'(ad); a_rd1_addr = 3'(ad);
      b_rd0_addr = 3'(ad); b_rd1_addr = 3'(ad);
      @(negedge clk);
      checks++;
      if (a_rd0_data !== 16'h0 || a_rd1_data !== 16'h0 || a_rd0_busy !== 1'b0 || a_rd1_busy !== 1'b0) begin
        failures++;
        $display("FAIL reset_a addr=%0d got=%h/%h busy=%b/%b exp=0", ad, a_rd0_data, a_rd1_data, a_rd0_busy, a_rd1_busy);
      end
      checks++;
      if (b_rd0_data !== 32'h0 || b_rd1_data !== 32'h0 || b_rd0_busy !== 1'b0 || b_rd1_busy !== 1'b0) begin
        failures++;
        $display("FAIL reset_b addr=%0d got=%h/%h busy=%b/%b exp=0", ad, b_rd0_data, b_rd1_data, b_rd0_busy, b_rd1_busy);
      end
    end
    checks++;
    if (a_busy_vec !== 8'h0 || b_busy_vec !== 6'h0) begin
      failures++;
      $display("FAIL reset_busy_vec got=%h/%h exp=0/0", a_busy_vec, b_busy_vec);
    end
  endtask

  task automatic test_basic_write();
    tick();
    a_wr_en = 1; a_wr_addr = 3; a_wr_data = 16'h1234;
    tick();
    a_wr_addr = 5; a_wr_data = 16'hBEEF;
    tick();
    drive_idle();
    a_rd0_addr = 3; a_rd1_addr = 5;
    @(negedge clk);
    checks++;
    if (a_rd0_data !== 16'h1234) begin
      failures++; $display("FAIL basic_rd0 got=%h exp=1234", a_rd0_data);
    end
    checks++;
    if (a_rd1_data !== 16'hBEEF) begin
      failures++; $display("FAIL basic_rd1 got=%h exp=beef", a_rd1_data);
    end
    for (int ad = 0; ad < 8; ad++) begin
      if (ad == 3 || ad == 5) continue;
      tick();
      a_rd0_addr = 3'(ad); a_rd1_addr = 3'(ad);
      @(negedge clk);
      checks++;
      if (a_rd0_data !== 16'h0 || a_rd1_data !== 16'h0) begin
        failures++; $display("FAIL basic_other addr=%0d got=%h/%h exp=0", ad, a_rd0_data, a_rd1_data);
      end
    end
  endtask

  task automatic test_bypass();
    tick();
    a_wr_en = 1; a_wr_addr = 2; a_wr_data = 16'hA5A5; a_rd0_addr = 2;
    b_wr_en = 1; b_wr_addr = 2; b_wr_data = 32'hA5A5; b_rd0_addr = 2;
    @(negedge clk);
    checks++;
    if (a_rd0_data !== 16'hA5A5 || a_rd0_busy !== 1'b0) begin
      failures++; $display("FAIL bypass_a_same_cycle got=%h busy=%b exp=a5a5 busy=0", a_rd0_data, a_rd0_busy);
    end
    checks++;
    if (b_rd0_data !== 32'h0) begin
      failures++; $display("FAIL nobypass_b_same_cycle got=%h exp=0", b_rd0_data);
    end
    tick();
    drive_idle();
    @(negedge clk);
    checks++;
    if (b_rd0_data !== 32'hA5A5) begin
      failures++; $display("FAIL nobypass_b_after_edge got=%h exp=a5a5", b_rd0_data);
    end
    checks++;
    if (a_rd0_data !== 16'hA5A5) begin
      failures++; $display("FAIL bypass_a_after_edge got=%h exp=a5a5", a_rd0_data);
    end
  endtask

  task automatic test_scoreboard();
    tick();
    a_rsv_en = 1; a_rsv_addr = 4; a_rd1_addr = 4;
    b_rsv_en = 1; b_rsv_addr = 4; b_rd1_addr = 4;
    @(negedge clk);
    checks++;
    if (a_rd1_busy !== 1'b0 || b_rd1_busy !== 1'b0) begin
      failures++; $display("FAIL sb_t got=%b/%b exp=0/0", a_rd1_busy, b_rd1_busy);
    end
    tick();
    drive_idle();
    @(negedge clk);
    checks++;
    if (a_busy_vec[4] !== 1'b1 || a_rd1_busy !== 1'b1 || b_busy_vec[4] !== 1'b1 || b_rd1_busy !== 1'b1) begin
      failures++;
      $display("FAIL sb_t1 got a=%b/%b b=%b/%b exp=1", a_busy_vec[4], a_rd1_busy, b_busy_vec[4], b_rd1_busy);
    end
    tick();
    a_wr_en = 1; a_wr_addr = 4; a_wr_data = 16'($urandom);
    b_wr_en = 1; b_wr_addr = 4; b_wr_data = $urandom;
    @(negedge clk);
    checks++;
    if (a_rd1_busy !== 1'b0 || a_busy_vec[4] !== 1'b1) begin
      failures++; $display("FAIL sb_t2_a rd1_busy=%b vec4=%b exp 0,1", a_rd1_busy, a_busy_vec[4]);
    end
    checks++;
    if (b_rd1_busy !== 1'b1) begin
      failures++; $display("FAIL sb_t2_b rd1_busy=%b exp=1", b_rd1_busy);
    end
    tick();
    drive_idle();
    @(negedge clk);
    checks++;
    if (a_busy_vec[4] !== 1'b0 || a_rd1_busy !== 1'b0 || b_busy_vec[4] !== 1'b0 || b_rd1_busy !== 1'b0) begin
      failures++;
      $display("FAIL sb_t3 got a=%b/%b b=%b/%b exp=0", a_busy_vec[4], a_rd1_busy, b_busy_vec[4], b_rd1_busy);
    end
  endtask

  task automatic test_same_index();
    tick();
    a_wr_en = 1; a_wr_addr = 6; a_wr_data = 16'h0F0F;
    a_rsv_en = 1; a_rsv_addr = 6; a_rd0_addr = 6;
    tick();
    drive_idle();
    @(negedge clk);
    checks++;
    if (a_rd0_data !== 16'h0F0F || a_busy_vec[6] !== 1'b1 || a_rd0_busy !== 1'b1) begin
      failures++;
      $display("FAIL same_idx got=%h vec6=%b busy=%b exp=0f0f 1 1", a_rd0_data, a_busy_vec[6], a_rd0_busy);
    end
    tick();
    a_wr_en = 1; a_wr_addr = 7; a_wr_data = 16'h5A5A;
    a_rsv_en = 1; a_rsv_addr = 1;
    tick();
    drive_idle();
    a_rd0_addr = 7; a_rd1_addr = 1;
    @(negedge clk);
    checks++;
    if (a_rd0_data !== 16'h5A5A || a_busy_vec[1] !== 1'b1 || a_busy_vec[7] !== 1'b0 || a_rd1_busy !== 1'b1) begin
      failures++;
      $display("FAIL diff_idx got=%h vec=%b rd1_busy=%b exp=5a5a", a_rd0_data, a_busy_vec, a_rd1_busy);
    end
    checks++;
    if (a_busy_vec !== exp_a_vec()) begin
      failures++; $display("FAIL diff_idx_vec got=%b exp=%b", a_busy_vec, exp_a_vec());
    end
  endtask

  task automatic test_reset_mid();
    tick();
    a_wr_en = 1; a_wr_addr = 1; a_wr_data = 16'h7777;
    tick();
    a_wr_en = 0; a_rsv_en = 1; a_rsv_addr = 2;
    tick();
    drive_idle();
    a_rd0_addr = 1;
    @(negedge clk);
    checks++;
    if (a_rd0_data !== 16'h7777 || a_busy_vec[2] !== 1'b1) begin
      failures++; $display("FAIL rstmid_pre got=%h vec2=%b exp=7777 1", a_rd0_data, a_busy_vec[2]);
    end
    tick();
    rst_n = 0;
    a_wr_en = 1; a_wr_addr = 1; a_wr_data = 16'h1111;
    a_rsv_en = 1; a_rsv_addr = 3;
    tick();
    rst_n = 1;
    drive_idle();
    @(negedge clk);
    checks++;
    if (a_rd0_data !== 16'h0 || a_busy_vec !== 8'h0 || b_busy_vec !== 6'h0) begin
      failures++; $display("FAIL rstmid_post got=%h vec=%h/%h exp=0", a_rd0_data, a_busy_vec, b_busy_vec);
    end
  endtask

  task automatic test_zero_reg();
    tick();
    b_wr_en = 1; b_wr_addr = 0; b_wr_data = 32'hFFFFFFFF; b_rd0_addr = 0;
    @(negedge clk);
    checks++;
    if (b_rd0_data !== 32'h0) begin
      failures++; $display("FAIL zr_write_r0_same got=%h exp=0", b_rd0_data);
    end
    tick();
    drive_idle();
    b_rsv_en = 1; b_rsv_addr = 0;
    @(negedge clk);
    checks++;
    if (b_rd0_data !== 32'h0) begin
      failures++; $display("FAIL zr_write_r0 got=%h exp=0", b_rd0_data);
    end
    tick();
    drive_idle();
    @(negedge clk);
    checks++;
    if (b_busy_vec !== 6'h0 || b_rd0_busy !== 1'b0) begin
      failures++; $display("FAIL zr_rsv_r0 vec=%b busy=%b exp=0", b_busy_vec, b_rd0_busy);
    end
    for (int ad = 1; ad < 6; ad++) begin
      tick();
      b_wr_en = 1; b_wr_addr = 3'(ad); b_wr_data = $urandom;
    end
    tick();
    b_wr_en = 1; b_wr_addr = 7; b_wr_data = $urandom;
    b_rsv_en = 1; b_rsv_addr = 6;
    tick();
    drive_idle();
    for (int ad = 0; ad < 8; ad++) begin
      if (ad > 0) tick();
      b_rd0_addr = 3'(ad); b_rd1_addr = 3'(ad);
      @(negedge clk);
      checks++;
      if (b_rd0_data !== exp_b_data(3'(ad)) || b_rd1_data !== exp_b_data(3'(ad))) begin
        failures++;
        $display("FAIL zr_readback addr=%0d got=%h/%h exp=%h", ad, b_rd0_data, b_rd1_data, exp_b_data(3'(ad)));
      end
    end
    checks++;
    if (b_rd0_data !== 32'h0 || b_rd0_busy !== 1'b0 || b_busy_vec !== 6'h0) begin
      failures++; $display("FAIL zr_addr7 got=%h busy=%b vec=%b exp=0", b_rd0_data, b_rd0_busy, b_busy_vec);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 500; c++) begin
      tick();
      rst_n = ($urandom_range(0, 39) != 0);
      a_wr_en = 1'($urandom_range(0, 1)); a_wr_addr = 3'($urandom); a_wr_data = 16'($urandom);
      a_rsv_en = 1'($urandom_range(0, 1)); a_rsv_addr = 3'($urandom);
      a_rd0_addr = 3'($urandom); a_rd1_addr = ($urandom_range(0, 3) == 0) ? a_wr_addr : 3'($urandom);
      b_wr_en = 1'($urandom_range(0, 1)); b_wr_addr = 3'($urandom); b_wr_data = $urandom;
      b_rsv_en = 1'($urandom_range(0, 1)); b_rsv_addr = 3'($urandom);
      b_rd0_addr = 3'($urandom); b_rd1_addr = 3'($urandom);
      @(negedge clk);
      checks++;
      if (a_busy_vec !== exp_a_vec() || b_busy_vec !== exp_b_vec()) begin
        failures++;
        $display("FAIL rnd_vec cyc=%0d got=%b/%b exp=%b/%b", c, a_busy_vec, b_busy_vec, exp_a_vec(), exp_b_vec());
      end
      if (rst_n) begin
        checks++;
        if (a_rd0_data !== exp_a_data(a_rd0_addr) || a_rd1_data !== exp_a_data(a_rd1_addr) ||
            a_rd0_busy !== exp_a_busy(a_rd0_addr) || a_rd1_busy !== exp_a_busy(a_rd1_addr)) begin
          failures++;
          $display("FAIL rnd_a cyc=%0d got=%h/%h %b/%b exp=%h/%h %b/%b", c, a_rd0_data, a_rd1_data,
                   a_rd0_busy, a_rd1_busy, exp_a_data(a_rd0_addr), exp_a_data(a_rd1_addr),
                   exp_a_busy(a_rd0_addr), exp_a_busy(a_rd1_addr));
        end
        checks++;
        if (b_rd0_data !== exp_b_data(b_rd0_addr) || b_rd1_data !== exp_b_data(b_rd1_addr) ||
            b_rd0_busy !== exp_b_busy(b_rd0_addr) || b_rd1_busy !== exp_b_busy(b_rd1_addr)) begin
          failures++;
          $display("FAIL rnd_b cyc=%0d got=%h/%h %b/%b exp=%h/%h %b/%b", c, b_rd0_data, b_rd1_data,
                   b_rd0_busy, b_rd1_busy, exp_b_data(b_rd0_addr), exp_b_data(b_rd1_addr),
                   exp_b_busy(b_rd0_addr), exp_b_busy(b_rd1_addr));
        end
      end
    end
    tick();
    rst_n = 1;
    drive_idle();
  endtask

  initial begin
    rst_n = 0;
    drive_idle();
    a_rd0_addr = 0; a_rd1_addr = 0; b_rd0_addr = 0; b_rd1_addr = 0;
    test_reset();
    test_basic_write();
    test_bypass();
    test_scoreboard();
    test_same_index();
    test_reset_mid();
    test_zero_reg();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
Parametrised successor to the 8x16 single-port register file for the datapath. It provides N registers of configurable width, two independent combinational read ports, one synchronous write port, optional write-to-read bypass and an optional hardwired-zero register 0. A per-register busy scoreboard tracks registers with a pending writeback so the controller can stall on read-after-write hazards.

Parameters:
WIDTH, 16, data width of each register in bits
NREGS, 8, number of registers (2..64; need not be a power of 2)
AW, $clog2(NREGS), address width (derived; not overridden)
BYPASS, 1, 1 = a same-cycle write is forwarded to the read ports; 0 = reads return the pre-write value
ZERO_REG, 0, 1 = register 0 always reads 0, ignores writes and is never busy

Ports:
clk  in  1  system clock; all state updates on the rising edge
rst_n  in  1  synchronous active-low reset
wr_en  in  1  write strobe
wr_addr  in  AW  write register index
wr_data  in  WIDTH  write data
rsv_en  in  1  reserve strobe; marks rsv_addr busy (a producer has been issued)
rsv_addr  in  AW  register index to reserve
rd0_addr  in  AW  read port 0 index
rd0_data  out  WIDTH  read port 0 data (combinational)
rd0_busy  out  1  read port 0 register has a pending write
rd1_addr  in  AW  read port 1 index
rd1_data  out  WIDTH  read port 1 data (combinational)
rd1_busy  out  1  read port 1 register has a pending write
busy_vec  out  NREGS  registered scoreboard; bit i = register i is busy

Behaviour:
- Interface: one clock, clk. Reset rst_n is synchronous and active-low. There is no asynchronous path.
- Reset: on a rising edge with rst_n=0, every register becomes 0 and busy_vec becomes 0. wr_en and rsv_en are ignored on that edge.
  - After that edge, rd*_data=0 and rd*_busy=0 for every address.
  - Reset in the middle of a stream of writes or reservations discards all pending state.
- Write: on a rising edge with rst_n=1, wr_en=1 and a valid address, reg[wr_addr] <= wr_data. Write latency is 1 cycle.
- Valid address: addr < NREGS, and addr != 0 when ZERO_REG=1.
  - Writes and reserves to an invalid address are dropped with no side effects.
  - Reads of an invalid address return 0 with busy=0.
- Read: rdX_data = reg[rdX_addr] combinationally. Both ports are independent and may use the same address.
- Bypass, BYPASS=1: if wr_en=1, the write is valid and wr_addr==rdX_addr, then rdX_data=wr_data in the same cycle. This does not depend on rst_n; during a reset cycle the read value is not checked.
- Bypass, BYPASS=0: rdX_data shows the old value until the edge.
- Scoreboard update at each rising edge with rst_n=1:
  - a valid wr_en clears busy[wr_addr];
  - a valid rsv_en sets busy[rsv_addr].
- Same-index write and reserve in one cycle: the reserve wins, and busy stays or becomes 1 because a new producer has been issued. The data write still occurs.
- Write and reserve to different indices in one cycle: both take effect.
- Reserving a register that is already busy leaves it busy (no counting).
- Writing a register that is not busy is legal; busy stays 0.
- rdX_busy = busy_vec[rdX_addr]. With BYPASS=1, it is forced to 0 when a valid same-cycle write hits rdX_addr, because the data is forwarded.
- With ZERO_REG=1, busy_vec[0] is constant 0.
- There is no multi-cycle FSM. State consists of the register array plus the busy_vec flop vector. All outputs are defined for every input combination; no X may propagate from an unwritten register after reset.

Test Plan:
- Reset, then write 16'h1234 to R3 and 16'hBEEF to R5. With rd0_addr=3 and rd1_addr=5, the next cycle must give rd0_data=16'h1234 and rd1_data=16'hBEEF. All other addresses read 0.
- BYPASS=1: in the same cycle, wr_en=1, wr_addr=2, wr_data=16'hA5A5, rd0_addr=2. rd0_data must be 16'hA5A5 in that cycle. BYPASS=0 build: it must show the old value 0, then 16'hA5A5 after the edge.
- Scoreboard: rsv_en on R4 in cycle t gives busy_vec[4]=1 and rd1_busy=1 at t+1. A write to R4 at t+2 gives busy=0 at t+3. With BYPASS=1, rd1_busy=0 already in cycle t+2.
- Same cycle wr_en and rsv_en both on R6 with wr_data=16'h0F0F: after the edge, R6=16'h0F0F and busy_vec[6]=1.
- ZERO_REG=1, NREGS=6, WIDTH=32:
  - a write of 32'hFFFFFFFF to R0 must read back 0;
  - a reserve on R0 must leave busy_vec=0;
  - a write to address 7 must leave all registers unchanged;
  - reading address 7 must return 0.
- Write R1=16'h7777 and reserve R2, then assert rst_n=0 for one edge while wr_en=1 targets R1 with 16'h1111. Afterwards, R1 must read 0 and busy_vec=0.
